// File: rtl/jogador_automatico.sv
// Autonomous player for jogo_desafio_memoria.
//
// Watches the game's LED display, captures the sequence shown in each round, replays it as
// one-hot button pulses once the game waits for jogadas, then enters a new jogada (the last
// captured LED rotated left by one position) when the game asks for it.
//
// Ports:
//   clock          system clock, rising edge
//   reset          asynchronous, active-low
//   iniciar        start request, sampled in OCIOSO and FIM
//   leds           game LED display (one-hot while shown, 0000 otherwise)
//   espera_jogada  game waiting for the repeated jogadas
//   espera_nova    game waiting for the new jogada of the round
//   fim            game finished (ganhou | perdeu)
//   jogar          one-cycle start pulse to the game
//   botoes         one-hot button press to the game, 0000 when idle
//   ocupado        high in every state except OCIOSO and FIM
//   erro           sticky: malformed LED code or capture overflow
//   db_estado      current state code
//   db_contagem    entries captured this round
module jogador_automatico #(
  parameter int unsigned MAX_JOGADAS  = 16,
  parameter int unsigned PRESS_CICLOS = 2,
  parameter int unsigned GAP_CICLOS   = 2
) (
  input  logic                               clock,
  input  logic                               reset,
  input  logic                               iniciar,
  input  logic [3:0]                         leds,
  input  logic                               espera_jogada,
  input  logic                               espera_nova,
  input  logic                               fim,
  output logic                               jogar,
  output logic [3:0]                         botoes,
  output logic                               ocupado,
  output logic                               erro,
  output logic [3:0]                         db_estado,
  output logic [$clog2(MAX_JOGADAS+1)-1:0]   db_contagem
);

  localparam int unsigned CW   = $clog2(MAX_JOGADAS + 1);
  localparam int unsigned AW   = (MAX_JOGADAS > 1) ? $clog2(MAX_JOGADAS) : 1;
  localparam int unsigned TMAX = (PRESS_CICLOS > GAP_CICLOS) ? PRESS_CICLOS : GAP_CICLOS;
  localparam int unsigned TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

  typedef enum logic [3:0] {
    StOcioso      = 4'd0,
    StInicia      = 4'd1,
    StCaptura     = 4'd2,
    StPressiona   = 4'd3,
    StSolta       = 4'd4,
    StAguardaNova = 4'd5,
    StNova        = 4'd6,
    StSoltaNova   = 4'd7,
    StFim         = 4'd8
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   count_q, count_d;
  logic [AW-1:0]   index_q, index_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic [3:0]      leds_prev_q;
  logic            erro_q, erro_d;
  logic            jogar_q, jogar_d;
  logic            ocupado_q, ocupado_d;
  logic [3:0]      botoes_q, botoes_d;

  logic [3:0]      mem_q [MAX_JOGADAS];
  logic            mem_we;
  logic [AW-1:0]   wr_addr;
  logic [AW-1:0]   last_addr;
  logic [3:0]      last_led;

  logic            led_event;
  logic            leds_one_hot;
  logic            press_done;
  logic            gap_done;
  logic            index_last;

  // A new LED is recognised only on the rising edge of the display becoming non-zero.
  assign led_event    = (leds_prev_q == 4'b0000) && (leds != 4'b0000);
  assign leds_one_hot = (leds != 4'b0000) && ((leds & (leds - 4'd1)) == 4'b0000);

  assign press_done = (timer_q == TW'(PRESS_CICLOS - 1));
  assign gap_done   = (timer_q == TW'(GAP_CICLOS - 1));
  assign index_last = (CW'(index_q) == (count_q - CW'(1)));

  assign wr_addr   = AW'(count_q);
  assign last_addr = AW'(count_q - CW'(1));
  assign last_led  = mem_q[last_addr];

  // Next-state logic; fim outranks every other condition outside OCIOSO/FIM.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    index_d = index_q;
    timer_d = timer_q;
    erro_d  = erro_q;
    mem_we  = 1'b0;

    if (fim && (state_q != StOcioso) && (state_q != StFim)) begin
      state_d = StFim;
      timer_d = '0;
    end else begin
      unique case (state_q)
        StOcioso, StFim: begin
          if (iniciar) begin
            state_d = StInicia;
            erro_d  = 1'b0;
            count_d = '0;
            index_d = '0;
            timer_d = '0;
          end
        end

        StInicia: state_d = StCaptura;

        StCaptura: begin
          if (led_event) begin
            // Malformed code or a full memory ends the game; the memory never wraps.
            if (!leds_one_hot || (count_q == CW'(MAX_JOGADAS))) begin
              erro_d  = 1'b1;
              state_d = StFim;
            end else begin
              mem_we  = 1'b1;
              count_d = count_q + CW'(1);
            end
          end else if (espera_jogada && (count_q != '0)) begin
            index_d = '0;
            timer_d = '0;
            state_d = StPressiona;
          end
        end

        StPressiona: begin
          if (press_done) begin
            timer_d = '0;
            state_d = StSolta;
          end else begin
            timer_d = timer_q + TW'(1);
          end
        end

        StSolta: begin
          if (gap_done) begin
            timer_d = '0;
            if (index_last) begin
              state_d = StAguardaNova;
            end else begin
              index_d = index_q + AW'(1);
              state_d = StPressiona;
            end
          end else begin
            timer_d = timer_q + TW'(1);
          end
        end

        StAguardaNova: begin
          if (espera_nova) begin
            timer_d = '0;
            state_d = StNova;
          end
        end

        StNova: begin
          if (press_done) begin
            timer_d = '0;
            state_d = StSoltaNova;
          end else begin
            timer_d = timer_q + TW'(1);
          end
        end

        StSoltaNova: begin
          if (gap_done) begin
            // The game shows the whole sequence again next round, so capture restarts at 0.
            timer_d = '0;
            count_d = '0;
            state_d = StCaptura;
          end else begin
            timer_d = timer_q + TW'(1);
          end
        end

        default: state_d = StOcioso;
      endcase
    end
  end

  // Outputs are decoded from the next state so they are registered alongside it.
  always_comb begin
    jogar_d   = (state_d == StInicia);
    ocupado_d = (state_d != StOcioso) && (state_d != StFim);
    botoes_d  = 4'b0000;
    if (state_d == StPressiona) begin
      botoes_d = mem_q[index_d];
    end else if (state_d == StNova) begin
      botoes_d = {last_led[2:0], last_led[3]};
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= StOcioso;
      count_q     <= '0;
      index_q     <= '0;
      timer_q     <= '0;
      leds_prev_q <= 4'b0000;
      erro_q      <= 1'b0;
      jogar_q     <= 1'b0;
      ocupado_q   <= 1'b0;
      botoes_q    <= 4'b0000;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      index_q     <= index_d;
      timer_q     <= timer_d;
      leds_prev_q <= leds;
      erro_q      <= erro_d;
      jogar_q     <= jogar_d;
      ocupado_q   <= ocupado_d;
      botoes_q    <= botoes_d;
    end
  end

  // Capture memory needs no reset: entries are always written before being read.
  always_ff @(posedge clock) begin
    if (mem_we) begin
      mem_q[wr_addr] <= leds;
    end
  end

  assign jogar       = jogar_q;
  assign botoes      = botoes_q;
  assign ocupado     = ocupado_q;
  assign erro        = erro_q;
  assign db_estado   = state_q;
  assign db_contagem = count_q;

endmodule

// File: tb/tb_jogador_automatico.sv
module tb_jogador_automatico;

  localparam int PRESS = 2;
  localparam int GAP   = 2;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       iniciar = 1'b0;
  logic [3:0] leds = 4'b0000;
  logic       espera_jogada = 1'b0;
  logic       espera_nova = 1'b0;
  logic       fim = 1'b0;
  logic       jogar;
  logic [3:0] botoes;
  logic       ocupado;
  logic       erro;
  logic [3:0] db_estado;
  logic [4:0] db_contagem;

  int checks = 0;
  int errors = 0;

  logic [3:0] game_q [$];

  typedef struct {
    logic [3:0] led;
    bit         err;
    logic [3:0] press;
    logic [3:0] nova;
  } vec_t;

  vec_t vecs [7];

  jogador_automatico dut (
    .clock         (clock),
    .reset         (reset),
    .iniciar       (iniciar),
    .leds          (leds),
    .espera_jogada (espera_jogada),
    .espera_nova   (espera_nova),
    .fim           (fim),
    .jogar         (jogar),
    .botoes        (botoes),
    .ocupado       (ocupado),
    .erro          (erro),
    .db_estado     (db_estado),
    .db_contagem   (db_contagem)
  );

  always #5 clock = ~clock;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish (errors=%0d)", errors);
    $fatal(1);
  end

  // Next button in the 0001->0010->0100->1000->0001 cycle, as plain arithmetic.
  function automatic logic [3:0] next_button(input logic [3:0] v);
    return (v == 4'd8) ? 4'd1 : 4'(v * 2);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    iniciar = 1'b0;
    leds = 4'b0000;
    espera_jogada = 1'b0;
    espera_nova = 1'b0;
    fim = 1'b0;
    tick(2);
    reset = 1'b1;
    tick(1);
  endtask

  task automatic start_game();
    iniciar = 1'b1;
    tick(1);
    iniciar = 1'b0;
    tick(1);
  endtask

  task automatic show_led(input logic [3:0] v, input int on, input int off);
    leds = v;
    tick(on);
    leds = 4'b0000;
    tick(off);
  endtask

  // Waits (bounded) for a press, then measures how long it lasts.
  task automatic get_press(output logic [3:0] val, output int lead, output int width);
    lead = 0;
    while (botoes === 4'b0000 && lead < 40) begin
      tick(1);
      lead++;
    end
    val = botoes;
    width = 0;
    while (botoes === val && val !== 4'b0000 && width < 40) begin
      tick(1);
      width++;
    end
  endtask

  // One round against the sequence model in game_q: show all, expect replay plus new jogada.
  task automatic play_round();
    logic [3:0] v;
    int lead, width;
    foreach (game_q[i]) show_led(game_q[i], $urandom_range(1, 3), $urandom_range(1, 3));
    check("round_count", db_contagem, game_q.size());
    espera_jogada = 1'b1;
    foreach (game_q[i]) begin
      get_press(v, lead, width);
      check("replay_value", v, game_q[i]);
      check("replay_width", width, PRESS);
      check("replay_lead", lead, (i == 0) ? 1 : GAP);
    end
    espera_jogada = 1'b0;
    espera_nova = 1'b1;
    get_press(v, lead, width);
    espera_nova = 1'b0;
    check("nova_value", v, next_button(game_q[game_q.size() - 1]));
    check("nova_width", width, PRESS);
    check("nova_lead", lead, GAP + 1);
    tick(GAP);
    check("round_end_state", db_estado, 2);
    check("round_end_count", db_contagem, 0);
  endtask

  initial begin
    logic [3:0] v;
    int lead, width;

    vecs[0] = '{4'b0001, 1'b0, 4'b0001, 4'b0010};
    vecs[1] = '{4'b0010, 1'b0, 4'b0010, 4'b0100};
    vecs[2] = '{4'b0100, 1'b0, 4'b0100, 4'b1000};
    vecs[3] = '{4'b1000, 1'b0, 4'b1000, 4'b0001};
    vecs[4] = '{4'b0011, 1'b1, 4'b0000, 4'b0000};
    vecs[5] = '{4'b1111, 1'b1, 4'b0000, 4'b0000};
    vecs[6] = '{4'b0110, 1'b1, 4'b0000, 4'b0000};

    // Reset values and start handshake.
    #1 reset = 1'b0;
    tick(2);
    check("rst_jogar", jogar, 0);
    check("rst_botoes", botoes, 0);
    check("rst_ocupado", ocupado, 0);
    check("rst_erro", erro, 0);
    check("rst_estado", db_estado, 0);
    check("rst_contagem", db_contagem, 0);
    reset = 1'b1;
    tick(1);
    show_led(4'b0011, 2, 2);
    check("idle_ignores_leds", erro, 0);
    iniciar = 1'b1;
    tick(1);
    iniciar = 1'b0;
    check("start_jogar", jogar, 1);
    check("start_estado", db_estado, 1);
    check("start_ocupado", ocupado, 1);
    tick(1);
    check("capt_jogar", jogar, 0);
    check("capt_estado", db_estado, 2);
    check("capt_botoes", botoes, 0);

    // Table: single-LED rounds, valid and malformed codes.
    for (int k = 0; k < 7; k++) begin
      do_reset();
      start_game();
      show_led(vecs[k].led, 2, 2);
      if (vecs[k].err) begin
        check("bad_erro", erro, 1);
        check("bad_estado", db_estado, 8);
        check("bad_botoes", botoes, 0);
        check("bad_ocupado", ocupado, 0);
        iniciar = 1'b1;
        tick(1);
        iniciar = 1'b0;
        check("restart_erro", erro, 0);
        check("restart_jogar", jogar, 1);
        tick(1);
        check("restart_contagem", db_contagem, 0);
      end else begin
        espera_jogada = 1'b1;
        get_press(v, lead, width);
        espera_jogada = 1'b0;
        check("tbl_press", v, vecs[k].press);
        check("tbl_press_width", width, PRESS);
        espera_nova = 1'b1;
        get_press(v, lead, width);
        espera_nova = 1'b0;
        check("tbl_gap_lead", lead, GAP + 1);
        check("tbl_nova", v, vecs[k].nova);
        check("tbl_nova_width", width, PRESS);
        tick(GAP);
        check("tbl_contagem", db_contagem, 0);
      end
    end

    // Randomised full game: 16 rounds, each extended by the player's own new jogada.
    do_reset();
    start_game();
    game_q.delete();
    game_q.push_back(4'(1 << $urandom_range(0, 3)));
    for (int r = 1; r <= 16; r++) begin
      play_round();
      if (r < 16) game_q.push_back(next_button(game_q[game_q.size() - 1]));
    end
    fim = 1'b1;
    tick(1);
    fim = 1'b0;
    check("game_estado", db_estado, 8);
    check("game_erro", erro, 0);
    check("game_ocupado", ocupado, 0);

    // Capture overflow: the 17th event in a round is an error.
    do_reset();
    start_game();
    for (int i = 0; i < 16; i++) show_led(4'(1 << $urandom_range(0, 3)), 1, 1);
    check("full_contagem", db_contagem, 16);
    check("full_erro", erro, 0);
    show_led(4'b0001, 1, 1);
    check("ovf_erro", erro, 1);
    check("ovf_estado", db_estado, 8);

    // fim mid-press cuts the press on the next edge.
    do_reset();
    start_game();
    show_led(4'b0100, 2, 2);
    espera_jogada = 1'b1;
    tick(1);
    check("pre_fim_botoes", botoes, 4'b0100);
    fim = 1'b1;
    tick(1);
    fim = 1'b0;
    espera_jogada = 1'b0;
    check("fim_botoes", botoes, 0);
    check("fim_estado", db_estado, 8);
    check("fim_erro", erro, 0);

    // Reset mid-press clears outputs without a clock edge.
    iniciar = 1'b1;
    tick(1);
    iniciar = 1'b0;
    tick(1);
    show_led(4'b0100, 2, 2);
    espera_jogada = 1'b1;
    tick(1);
    check("pre_rst_botoes", botoes, 4'b0100);
    #2 reset = 1'b0;
    #1;
    check("async_botoes", botoes, 0);
    check("async_ocupado", ocupado, 0);
    check("async_estado", db_estado, 0);
    check("async_jogar", jogar, 0);
    espera_jogada = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    tick(1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
